// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio record/playback path (deserializer and
// serializer): default sample width and the deserializer FSM state encoding.
// -----------------------------------------------------------------------------
package audio_pkg;

    // Default number of bits captured per audio sample
    localparam int AUDIO_DATA_WIDTH = 32'sd16;

    // Deserializer FSM states
    typedef enum logic [2:0] {
        DES_IDLE       = 3'd0,
        DES_WAIT_FRAME = 3'd1,
        DES_SKIP       = 3'd2,
        DES_SHIFT      = 3'd3,
        DES_HOLD       = 3'd4
    } des_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// STAGES-deep flip-flop synchroniser for one asynchronous input, followed by
// a history flop so that rising/falling edges are derived purely from the
// last two synchronised samples.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset (clears chain and history)
//   d_i     asynchronous input
//   rise_o  one-cycle pulse: synchronised input went 0 -> 1
//   fall_o  one-cycle pulse: synchronised input went 1 -> 0
// -----------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int STAGES = 32'sd2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;
    logic              sync_s;

    // Synchroniser chain plus one-sample history of the synchronised value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign sync_s = chain_q[STAGES-1];
    assign rise_o = sync_s & ~prev_q;
    assign fall_o = ~sync_s & prev_q;

endmodule

// File: rtl/audio_deserializer.sv
// -----------------------------------------------------------------------------
// audio_deserializer
// Record-path front end. Receives an I2S stream (bclk, lrclk, sdata), all
// asynchronous to clock, and assembles MSB-first DATA_WIDTH-bit samples from
// the left slot. des_done pulses once per captured sample; framing_err pulses
// when a slot ends before DATA_WIDTH bits were captured.
//
// Optional feature (macro AUDIO_DES_MONO_MIX_EN): the right slot is captured
// as well and sample = (L + R) >>> 1, with one des_done per frame issued after
// the right word. Default build (macro undefined): left slot only.
//
// Ports:
//   clock        system clock, posedge
//   reset        asynchronous active-low reset
//   enable       record active; low forces IDLE
//   bclk         serial bit clock (<= clock/4), asynchronous
//   lrclk        word select, 0 = left slot, 1 = right slot, asynchronous
//   sdata        serial data, sampled on bclk rising edge, asynchronous
//   sample       last completed sample (two's complement)
//   des_done     one-cycle pulse: sample updated this cycle
//   framing_err  one-cycle pulse: slot ended short, word discarded
// -----------------------------------------------------------------------------
module audio_deserializer
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH  = AUDIO_DATA_WIDTH,
    parameter int SYNC_STAGES = 32'sd2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  bclk,
    input  logic                  lrclk,
    input  logic                  sdata,
    output logic [DATA_WIDTH-1:0] sample,
    output logic                  des_done,
    output logic                  framing_err
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH) + 32'sd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic                   bclk_rise_s;
    logic                   lr_rise_s;
    logic                   lr_fall_s;
    logic                   lr_fall_unused_s;
    logic [SYNC_STAGES-1:0] sdata_sync_q;
    logic                   sdata_s;

    des_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-2:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  sample_q, sample_d;
    logic                   des_done_q, des_done_d;
    logic                   framing_err_q, framing_err_d;
    logic [DATA_WIDTH-1:0]  word_s;

`ifdef AUDIO_DES_MONO_MIX_EN
    logic [DATA_WIDTH-1:0]  left_q, left_d;
    logic                   right_slot_q, right_slot_d;
    logic signed [DATA_WIDTH:0] mix_sum_s;
    logic [DATA_WIDTH-1:0]  mix_s;
`endif

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (bclk),
        .rise_o (bclk_rise_s),
        .fall_o (lr_fall_unused_s)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_lrclk_sync (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (lrclk),
        .rise_o (lr_rise_s),
        .fall_o (lr_fall_s)
    );

    // sdata synchroniser, same depth as bclk so a synced bclk rise lines up
    // with the data bit sampled alongside it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sdata_sync_q <= '0;
        end else begin
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata};
        end
    end

    assign sdata_s = sdata_sync_q[SYNC_STAGES-1];
    assign word_s  = {shift_q, sdata_s};

`ifdef AUDIO_DES_MONO_MIX_EN
    // Average of left and right in one extra bit, arithmetic shift, truncate
    assign mix_sum_s = $signed({left_q[DATA_WIDTH-1], left_q})
                     + $signed({word_s[DATA_WIDTH-1], word_s});
    assign mix_s     = mix_sum_s[DATA_WIDTH:1];
`endif

    // Next-state logic: FSM, bit counter, shift register and output pulses
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        sample_d      = sample_q;
        des_done_d    = 1'b0;
        framing_err_d = 1'b0;
`ifdef AUDIO_DES_MONO_MIX_EN
        left_d        = left_q;
        right_slot_d  = right_slot_q;
`endif
        if (!enable) begin
            state_d = DES_IDLE;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                DES_IDLE: begin
                    state_d = DES_WAIT_FRAME;
                end
                DES_WAIT_FRAME: begin
                    if (lr_fall_s) begin
                        state_d = DES_SKIP;
`ifdef AUDIO_DES_MONO_MIX_EN
                        right_slot_d = 1'b0;
`endif
                    end else begin
                        state_d = DES_WAIT_FRAME;
                    end
                end
                DES_SKIP: begin
                    // First bclk rise of a slot carries no data of this word
                    if (bclk_rise_s) begin
                        state_d = DES_SHIFT;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d = DES_SKIP;
                    end
                end
                DES_SHIFT: begin
                    // A slot boundary here means the word is short; it takes
                    // priority over a coincident bit clock edge
                    if (lr_fall_s || lr_rise_s) begin
                        framing_err_d = 1'b1;
                        cnt_d         = {CNT_W{1'b0}};
                        if (lr_fall_s) begin
                            state_d = DES_SKIP;
                        end else begin
                            state_d = DES_WAIT_FRAME;
                        end
`ifdef AUDIO_DES_MONO_MIX_EN
                        right_slot_d = 1'b0;
`endif
                    end else if (bclk_rise_s) begin
                        shift_d = word_s[DATA_WIDTH-2:0];
                        if (cnt_q == CNT_LAST) begin
                            state_d = DES_HOLD;
`ifdef AUDIO_DES_MONO_MIX_EN
                            if (right_slot_q) begin
                                sample_d   = mix_s;
                                des_done_d = 1'b1;
                            end else begin
                                left_d = word_s;
                            end
`else
                            sample_d   = word_s;
                            des_done_d = 1'b1;
`endif
                        end else if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            cnt_d = cnt_q;
                        end
                    end else begin
                        state_d = DES_SHIFT;
                    end
                end
                DES_HOLD: begin
                    if (lr_fall_s) begin
                        state_d = DES_SKIP;
`ifdef AUDIO_DES_MONO_MIX_EN
                        right_slot_d = 1'b0;
                    end else if (lr_rise_s && !right_slot_q) begin
                        state_d      = DES_SKIP;
                        right_slot_d = 1'b1;
`endif
                    end else begin
                        state_d = DES_HOLD;
                    end
                end
                default: begin
                    state_d = DES_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= DES_IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            shift_q       <= '0;
            sample_q      <= '0;
            des_done_q    <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            sample_q      <= sample_d;
            des_done_q    <= des_done_d;
            framing_err_q <= framing_err_d;
        end
    end

`ifdef AUDIO_DES_MONO_MIX_EN
    // Left word holding register and current-slot flag for the mix
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            left_q       <= '0;
            right_slot_q <= 1'b0;
        end else begin
            left_q       <= left_d;
            right_slot_q <= right_slot_d;
        end
    end
`endif

    assign sample      = sample_q;
    assign des_done    = des_done_q;
    assign framing_err = framing_err_q;

endmodule

// File: tb/tb_audio_deserializer.sv
// -----------------------------------------------------------------------------
// tb_audio_deserializer
// Directed I2S frames into audio_deserializer; expected sample words and
// framing errors are queued as stimulus is issued, and a monitor pops and
// compares on each des_done / framing_err pulse.
// -----------------------------------------------------------------------------
module tb_audio_deserializer;

`ifdef AUDIO_DES_MONO_MIX_EN
    localparam bit MONO = 1'b1;
`else
    localparam bit MONO = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        bclk = 1'b0;
    logic        lrclk = 1'b1;
    logic        sdata = 1'b0;
    logic [15:0] sample;
    logic        des_done;
    logic        framing_err;

    int          checks = 0;
    int          failures = 0;
    int          done_seen = 0;
    int          done_expected = 0;
    logic [16:0] exp_q[$];
    logic [15:0] last_exp = 16'h0000;
    logic [15:0] prev_sample = 16'h0000;

    logic [15:0] vl[8];
    logic [15:0] vr[8];
    logic [15:0] ve_left[8];
    logic [15:0] ve_mono[8];

    audio_deserializer #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .sample      (sample),
        .des_done    (des_done),
        .framing_err (framing_err)
    );

    always #5 clock = ~clock;

    // One bclk period: lrclk/sdata change while bclk is low, then rise, fall
    task automatic bit_cycle(input logic lr, input logic d);
        @(negedge clock);
        lrclk = lr;
        sdata = d;
        repeat (4) @(negedge clock);
        bclk = 1'b1;
        repeat (4) @(negedge clock);
        bclk = 1'b0;
    endtask

    // Slot of nrises bclk rises; rise 0 is the I2S delay bit, rises 1..16 MSB first
    task automatic send_slot(input logic lr, input logic [15:0] word, input int nrises);
        logic d;
        for (int i = 0; i < nrises; i++) begin
            d = ((i >= 1) && (i <= 16)) ? word[16-i] : 1'b0;
            bit_cycle(lr, d);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b0, l, 32);
        send_slot(1'b1, r, 32);
    endtask

    task automatic push_done(input logic [15:0] v);
        exp_q.push_back({1'b0, v});
        done_expected++;
        last_exp = v;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the active edge
    always @(negedge clock) begin
        logic [16:0] e;
        if (!reset) begin
            prev_sample = sample;
        end else begin
            if (des_done && framing_err) begin
                checks++;
                failures++;
                $display("FAIL both_pulses des_done=%b framing_err=%b required=0/1 exclusive", des_done, framing_err);
            end
            if (des_done || framing_err) begin
                checks++;
                if (des_done) done_seen++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse des_done=%b framing_err=%b sample=%h required=no pulse",
                             des_done, framing_err, sample);
                end else begin
                    e = exp_q.pop_front();
                    if (framing_err && !e[16]) begin
                        failures++;
                        $display("FAIL pulse_kind actual=framing_err required=des_done sample %h", e[15:0]);
                    end else if (des_done && e[16]) begin
                        failures++;
                        $display("FAIL pulse_kind actual=des_done sample=%h required=framing_err", sample);
                    end else if (des_done && (sample !== e[15:0])) begin
                        failures++;
                        $display("FAIL sample_value actual=%h required=%h", sample, e[15:0]);
                    end
                end
            end else begin
                checks++;
                if (sample !== prev_sample) begin
                    failures++;
                    $display("FAIL sample_hold actual=%h required=%h", sample, prev_sample);
                end
            end
            prev_sample = sample;
        end
    end

    initial begin
        vl[0] = 16'hA5C3; vr[0] = 16'h1234; ve_left[0] = 16'hA5C3; ve_mono[0] = 16'hDBFB;
        vl[1] = 16'h0001; vr[1] = 16'h0000; ve_left[1] = 16'h0001; ve_mono[1] = 16'h0000;
        vl[2] = 16'h8000; vr[2] = 16'h0000; ve_left[2] = 16'h8000; ve_mono[2] = 16'hC000;
        vl[3] = 16'hFFFF; vr[3] = 16'h0000; ve_left[3] = 16'hFFFF; ve_mono[3] = 16'hFFFF;
        vl[4] = 16'h5A5A; vr[4] = 16'h0000; ve_left[4] = 16'h5A5A; ve_mono[4] = 16'h2D2D;
        vl[5] = 16'h7FFF; vr[5] = 16'h7FFF; ve_left[5] = 16'h7FFF; ve_mono[5] = 16'h7FFF;
        vl[6] = 16'h8000; vr[6] = 16'h0000; ve_left[6] = 16'h8000; ve_mono[6] = 16'hC000;
        vl[7] = 16'hA5C3; vr[7] = 16'h1234; ve_left[7] = 16'hA5C3; ve_mono[7] = 16'hDBFB;

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_sample", sample, 16'h0000);
        check("reset_des_done", {15'd0, des_done}, 16'h0000);
        check("reset_framing_err", {15'd0, framing_err}, 16'h0000);
        reset = 1'b1;
        enable = 1'b1;
        repeat (10) @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                // Short left slot: lrclk rises after 10 data bits
                exp_q.push_back({1'b1, 16'h0000});
                send_slot(1'b0, 16'hFFFF, 11);
                send_slot(1'b1, 16'h0000, 32);
            end
            push_done(MONO ? ve_mono[i] : ve_left[i]);
            send_frame(vl[i], vr[i]);
        end

        // enable dropped after 5 bits: no pulses, sample retained
        send_slot(1'b0, 16'h1111, 6);
        @(negedge clock);
        enable = 1'b0;
        repeat (10) @(negedge clock);
        enable = 1'b1;
        send_slot(1'b1, 16'h0000, 32);
        repeat (20) @(negedge clock);
        check("enable_drop_sample", sample, last_exp);

        // Asynchronous reset in the middle of a word (7 bits in)
        send_slot(1'b0, 16'hFFFF, 8);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_sample", sample, 16'h0000);
        check("midreset_des_done", {15'd0, des_done}, 16'h0000);
        check("midreset_framing_err", {15'd0, framing_err}, 16'h0000);
        repeat (5) @(negedge clock);
        reset = 1'b1;

        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clock);
        check("queue_drained", 16'(exp_q.size()), 16'h0000);
        check("des_done_count", 16'(done_seen), 16'(done_expected));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
